// File: rtl/bram_stream_loader.sv
// Streams wide input beats into NUM_PORTS parallel BRAM write lanes starting at a
// configurable base address; supports abort, length clamping and address wrap.
module bram_stream_loader #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_PORTS  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           cfg_base,
  input  logic [ADDR_WIDTH:0]             cfg_len,
  input  logic                            abort,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
  output logic [NUM_PORTS-1:0]            bram_en,
  output logic [NUM_PORTS-1:0]            bram_we,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0] bram_addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] bram_din,
  output logic                            busy,
  output logic                            done,
  output logic                            aborted,
  output logic [ADDR_WIDTH:0]             words_written
);

  // Word index needs headroom past 2^ADDR_WIDTH for the lanes of the final beat.
  localparam int IW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                            r_state;
  logic [ADDR_WIDTH-1:0]             r_base;
  logic [ADDR_WIDTH:0]               r_len;
  logic [IW-1:0]                     r_idx;
  logic                              r_s_ready;
  logic                              r_busy;
  logic                              r_done;
  logic                              r_aborted;
  logic [ADDR_WIDTH:0]               r_words;
  logic [NUM_PORTS-1:0]              r_bram_en;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   r_bram_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   r_bram_din;

  logic [ADDR_WIDTH:0]               w_len_clamped;
  logic [NUM_PORTS-1:0]              w_lane_en;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   w_lane_addr;
  logic [ADDR_WIDTH:0]               w_en_count;
  logic                              w_accept;
  logic                              w_last_beat;

  assign w_len_clamped = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
  assign w_accept      = s_valid && r_s_ready;
  assign w_last_beat   = (r_idx + IW'(NUM_PORTS)) >= {1'b0, r_len};

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_lane
      logic [IW-1:0] w_idx;
      assign w_idx          = r_idx + IW'(gi);
      assign w_lane_en[gi]  = w_idx < {1'b0, r_len};
      assign w_lane_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] = r_base + w_idx[ADDR_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    w_en_count = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (w_lane_en[k]) w_en_count = w_en_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_s_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_words     <= '0;
      r_bram_en   <= '0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
    end else begin
      r_bram_en <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_words <= '0;
            r_busy  <= 1'b1;
            if (w_len_clamped != '0) begin
              r_base    <= cfg_base;
              r_len     <= w_len_clamped;
              r_idx     <= '0;
              r_s_ready <= 1'b1;
              r_state   <= LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        LOAD: begin
          // Abort wins over a beat accepted in the same cycle: that beat is dropped.
          if (abort) begin
            r_state   <= IDLE;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
          end else if (w_accept) begin
            r_bram_en   <= w_lane_en;
            r_bram_addr <= w_lane_addr;
            r_bram_din  <= s_data;
            r_words     <= r_words + w_en_count;
            r_idx       <= r_idx + IW'(NUM_PORTS);
            if (w_last_beat) begin
              r_state   <= DONE;
              r_s_ready <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready       = r_s_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign words_written = r_words;
  assign bram_en       = r_bram_en;
  assign bram_we       = r_bram_en;
  assign bram_addr     = r_bram_addr;
  assign bram_din      = r_bram_din;

endmodule

// File: tb/tb_bram_stream_loader.sv
// Directed bench for bram_stream_loader (NUM_PORTS=2, ADDR_WIDTH=8, DATA_WIDTH=16).
module tb_bram_stream_loader;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NP = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     cfg_base;
  logic [AW:0]       cfg_len;
  logic              abort;
  logic              s_valid;
  logic              s_ready;
  logic [NP*DW-1:0]  s_data;
  logic [NP-1:0]     bram_en;
  logic [NP-1:0]     bram_we;
  logic [NP*AW-1:0]  bram_addr;
  logic [NP*DW-1:0]  bram_din;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [AW:0]       words_written;

  int n_checks = 0;
  int n_fail   = 0;

  bram_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .abort(abort), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .busy(busy), .done(done), .aborted(aborted), .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transaction line per write cycle, then the checks for that cycle.
  task automatic chk_wr(input string tag, input logic [1:0] en, input logic [7:0] a0,
                        input logic [7:0] a1, input logic [8:0] ww, input logic dn);
    $display("%s: en=%b we=%b addr0=%0d addr1=%0d ww=%0d done=%b", tag, bram_en, bram_we,
             bram_addr[7:0], bram_addr[15:8], words_written, done);
    chk({tag, " en"}, 64'(bram_en), 64'(en));
    chk({tag, " we"}, 64'(bram_we), 64'(en));
    if (en[0]) chk({tag, " addr0"}, 64'(bram_addr[7:0]), 64'(a0));
    if (en[1]) chk({tag, " addr1"}, 64'(bram_addr[15:8]), 64'(a1));
    chk({tag, " ww"}, 64'(words_written), 64'(ww));
    chk({tag, " done"}, 64'(done), 64'(dn));
  endtask

  task automatic launch(input logic [7:0] base, input logic [8:0] len);
    start = 1'b1; cfg_base = base; cfg_len = len;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0; abort = 1'b0;
    s_valid = 1'b0; s_data = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset s_ready", 64'(s_ready), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset en", 64'(bram_en), 64'd0);
    chk("reset ww", 64'(words_written), 64'd0);

    // len=7 from base 0, four back-to-back beats
    launch(8'd0, 9'd7);
    chk("t1 busy", 64'(busy), 64'd1);
    chk("t1 s_ready", 64'(s_ready), 64'd1);
    s_valid = 1'b1; s_data = 32'hA001_A000;
    step(); chk_wr("t1 beat1", 2'b11, 8'd0, 8'd1, 9'd2, 1'b0);
    chk("t1 din", 64'(bram_din), 64'h0000_0000_A001_A000);
    s_data = 32'hA003_A002;
    step(); chk_wr("t1 beat2", 2'b11, 8'd2, 8'd3, 9'd4, 1'b0);
    s_data = 32'hA005_A004;
    step(); chk_wr("t1 beat3", 2'b11, 8'd4, 8'd5, 9'd6, 1'b0);
    chk("t1 s_ready mid", 64'(s_ready), 64'd1);
    s_data = 32'hA007_A006;
    step(); chk_wr("t1 beat4", 2'b01, 8'd6, 8'd0, 9'd7, 1'b1);
    chk("t1 s_ready end", 64'(s_ready), 64'd0);
    chk("t1 busy done", 64'(busy), 64'd1);
    s_valid = 1'b0;
    step(); chk_wr("t1 idle", 2'b00, 8'd0, 8'd0, 9'd7, 1'b0);
    chk("t1 busy idle", 64'(busy), 64'd0);

    // address wrap from base 254
    launch(8'd254, 9'd4);
    s_valid = 1'b1;
    step(); chk_wr("t2 beat1", 2'b11, 8'd254, 8'd255, 9'd2, 1'b0);
    step(); chk_wr("t2 beat2", 2'b11, 8'd0, 8'd1, 9'd4, 1'b1);
    s_valid = 1'b0;
    step();

    // s_valid gaps: 1,0,0,1,1
    launch(8'd16, 9'd5);
    s_valid = 1'b1; step(); chk_wr("t3 c1", 2'b11, 8'd16, 8'd17, 9'd2, 1'b0);
    s_valid = 1'b0; step(); chk_wr("t3 c2", 2'b00, 8'd0, 8'd0, 9'd2, 1'b0);
    s_valid = 1'b0; step(); chk_wr("t3 c3", 2'b00, 8'd0, 8'd0, 9'd2, 1'b0);
    s_valid = 1'b1; step(); chk_wr("t3 c4", 2'b11, 8'd18, 8'd19, 9'd4, 1'b0);
    s_valid = 1'b1; step(); chk_wr("t3 c5", 2'b01, 8'd20, 8'd0, 9'd5, 1'b1);
    s_valid = 1'b0; step(); chk_wr("t3 c6", 2'b00, 8'd0, 8'd0, 9'd5, 1'b0);

    // abort together with the second beat of a len=8 load
    launch(8'd32, 9'd8);
    s_valid = 1'b1; step(); chk_wr("t4 beat1", 2'b11, 8'd32, 8'd33, 9'd2, 1'b0);
    abort = 1'b1; step(); chk_wr("t4 abort", 2'b00, 8'd0, 8'd0, 9'd2, 1'b0);
    chk("t4 aborted", 64'(aborted), 64'd1);
    chk("t4 s_ready", 64'(s_ready), 64'd0);
    chk("t4 busy", 64'(busy), 64'd0);
    abort = 1'b0; s_valid = 1'b0;
    step();
    chk("t4 aborted pulse", 64'(aborted), 64'd0);
    chk("t4 s_ready after", 64'(s_ready), 64'd0);

    // zero-length load
    launch(8'd5, 9'd0);
    chk_wr("t5 len0", 2'b00, 8'd0, 8'd0, 9'd0, 1'b1);
    chk("t5 busy", 64'(busy), 64'd1);
    step();
    chk("t5 busy after", 64'(busy), 64'd0);
    chk("t5 done after", 64'(done), 64'd0);

    // start during LOAD is ignored
    launch(8'd64, 9'd3);
    start = 1'b1; cfg_base = 8'd128; cfg_len = 9'd8; s_valid = 1'b1;
    step(); chk_wr("t6 beat1", 2'b11, 8'd64, 8'd65, 9'd2, 1'b0);
    start = 1'b0;
    step(); chk_wr("t6 beat2", 2'b01, 8'd66, 8'd0, 9'd3, 1'b1);
    s_valid = 1'b0;
    step();

    // asynchronous reset mid-load, then a normal load
    launch(8'd100, 9'd6);
    s_valid = 1'b1; step(); chk_wr("t7 beat1", 2'b11, 8'd100, 8'd101, 9'd2, 1'b0);
    rst = 1'b1;
    #1;
    chk("t7 rst en", 64'(bram_en), 64'd0);
    chk("t7 rst addr", 64'(bram_addr), 64'd0);
    chk("t7 rst din", 64'(bram_din), 64'd0);
    chk("t7 rst busy", 64'(busy), 64'd0);
    chk("t7 rst s_ready", 64'(s_ready), 64'd0);
    chk("t7 rst ww", 64'(words_written), 64'd0);
    step();
    rst = 1'b0; s_valid = 1'b0;
    step();
    chk("t7 post done", 64'(done), 64'd0);
    chk("t7 post aborted", 64'(aborted), 64'd0);
    chk("t7 post busy", 64'(busy), 64'd0);
    launch(8'd200, 9'd2);
    s_valid = 1'b1; step(); chk_wr("t7 reload", 2'b11, 8'd200, 8'd201, 9'd2, 1'b1);
    s_valid = 1'b0; step();

    // cfg_len=300 clamps to 256 words: 128 beats
    launch(8'd0, 9'd300);
    s_valid = 1'b1;
    for (int b = 0; b < 127; b++) step();
    chk_wr("t8 beat127", 2'b11, 8'd252, 8'd253, 9'd254, 1'b0);
    step(); chk_wr("t8 beat128", 2'b11, 8'd254, 8'd255, 9'd256, 1'b1);
    s_valid = 1'b0;
    step();
    chk("t8 s_ready", 64'(s_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
